// File: rtl/sva_result_collector.sv
// Result collector for SVA checker pulses: counts success, failure and lazy-success pulses,
// captures the first failing round, and queues one fail record per failing round.
module sva_result_collector #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             round_start,
  input  logic             succ,
  input  logic             fail,
  input  logic             lazy_succ,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_round,
  output logic [CNT_W-1:0] succ_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] lazy_cnt,
  output logic [CNT_W-1:0] round_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_round,
  output logic             overflow,
  output logic [1:0]       verdict
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PtrW-1:0]  PtrOne  = {{(PtrW-1){1'b0}}, 1'b1};
  localparam logic [PtrW:0]    OccOne  = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW:0]    OccFull = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic             sync_rst;
  logic             active;
  logic [CNT_W-1:0] cur_idx;

  logic [CNT_W-1:0] succ_cnt_q, fail_cnt_q, lazy_cnt_q, round_cnt_q;
  logic             round_fail_q;
  logic             ff_vld_q;
  logic [CNT_W-1:0] ff_round_q;
  logic             overflow_q;

  logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    occ_q;
  logic             push, pop, full, do_push;

  // clr has exactly the reset effect, so both fold into one synchronous clear.
  assign sync_rst = !sys_rst_n || clr;

  // The IDLE->RUN cycle already belongs to round 0, so its pulses are counted.
  assign active = (state_q == StRun) || round_start;

  always_comb begin
    cur_idx = round_cnt_q;
    if (state_q == StIdle) begin
      cur_idx = '0;
    end else if (round_start) begin
      cur_idx = round_cnt_q + CntOne;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (round_start) state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      succ_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      lazy_cnt_q  <= '0;
      round_cnt_q <= '0;
    end else begin
      if (active && succ && (succ_cnt_q != '1)) succ_cnt_q <= succ_cnt_q + CntOne;
      if (active && fail && (fail_cnt_q != '1)) fail_cnt_q <= fail_cnt_q + CntOne;
      if (active && lazy_succ && (lazy_cnt_q != '1)) lazy_cnt_q <= lazy_cnt_q + CntOne;
      if ((state_q == StRun) && round_start) round_cnt_q <= round_cnt_q + CntOne;
    end
  end

  // A fail coincident with round_start belongs to the new round, so set beats clear.
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      round_fail_q <= 1'b0;
    end else if (active) begin
      if (fail) begin
        round_fail_q <= 1'b1;
      end else if (round_start) begin
        round_fail_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      ff_vld_q   <= 1'b0;
      ff_round_q <= '0;
    end else if (active && fail && !ff_vld_q) begin
      ff_vld_q   <= 1'b1;
      ff_round_q <= cur_idx;
    end
  end

  assign push    = active && fail && (!round_fail_q || round_start);
  assign full    = (occ_q == OccFull);
  assign pop     = rec_valid && rec_ready;
  // On a full FIFO a simultaneous pop frees the slot being written.
  assign do_push = push && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= cur_idx;
        wptr_q        <= wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      if (do_push && !pop) begin
        occ_q <= occ_q + OccOne;
      end else if (pop && !do_push) begin
        occ_q <= occ_q - OccOne;
      end
      if (push && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    verdict = 2'b00;
    if (fail_cnt_q != '0) begin
      verdict = 2'b10;
    end else if (succ_cnt_q != '0) begin
      verdict = 2'b01;
    end else if (lazy_cnt_q != '0) begin
      verdict = 2'b11;
    end
  end

  assign rec_valid        = (occ_q != '0);
  assign rec_round        = mem_q[rptr_q];
  assign succ_cnt         = succ_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign lazy_cnt         = lazy_cnt_q;
  assign round_cnt        = round_cnt_q;
  assign first_fail_vld   = ff_vld_q;
  assign first_fail_round = ff_round_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_sva_result_collector.sv
// Directed bench for sva_result_collector: a CNT_W=16 instance for the main behaviour and a
// CNT_W=4 instance for saturation and round-counter wrap.
module tb_sva_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, rs, succ, fail, lazy, rdy;
  logic        rec_valid, ffv, ovf;
  logic [15:0] rec_round, succ_cnt, fail_cnt, lazy_cnt, round_cnt, ffr;
  logic [1:0]  verdict;

  logic        clr1, rs1, succ1, fail1, lazy1, rdy1;
  logic        rec_valid1, ffv1, ovf1;
  logic [3:0]  rec_round1, succ_cnt1, fail_cnt1, lazy_cnt1, round_cnt1, ffr1;
  logic [1:0]  verdict1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sva_result_collector #(.CNT_W(16), .FIFO_DEPTH(4)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .round_start(rs), .succ(succ), .fail(fail),
    .lazy_succ(lazy), .rec_valid(rec_valid), .rec_ready(rdy), .rec_round(rec_round),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt), .round_cnt(round_cnt),
    .first_fail_vld(ffv), .first_fail_round(ffr), .overflow(ovf), .verdict(verdict)
  );

  sva_result_collector #(.CNT_W(4), .FIFO_DEPTH(4)) u_dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr1), .round_start(rs1), .succ(succ1),
    .fail(fail1), .lazy_succ(lazy1), .rec_valid(rec_valid1), .rec_ready(rdy1),
    .rec_round(rec_round1), .succ_cnt(succ_cnt1), .fail_cnt(fail_cnt1), .lazy_cnt(lazy_cnt1),
    .round_cnt(round_cnt1), .first_fail_vld(ffv1), .first_fail_round(ffr1),
    .overflow(ovf1), .verdict(verdict1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {clr, rs, succ, fail, lazy, rdy} = '0;
    {clr1, rs1, succ1, fail1, lazy1, rdy1} = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rec_valid got %0h want 0", rec_valid); end
    n_cmp++; if (rec_round !== 16'd0) begin n_bad++; $display("FAIL reset_rec_round got %0h want 0", rec_round); end
    n_cmp++; if (succ_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_succ_cnt got %0h want 0", succ_cnt); end
    n_cmp++; if (fail_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_fail_cnt got %0h want 0", fail_cnt); end
    n_cmp++; if (lazy_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_lazy_cnt got %0h want 0", lazy_cnt); end
    n_cmp++; if (round_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_round_cnt got %0h want 0", round_cnt); end
    n_cmp++; if ({ffv, ffr} !== 17'd0) begin n_bad++; $display("FAIL reset_first_fail got %0h want 0", {ffv, ffr}); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0h want 0", ovf); end
    n_cmp++; if (verdict !== 2'b00) begin n_bad++; $display("FAIL reset_verdict got %0h want 0", verdict); end
  endtask

  task automatic test_idle_succ();
    do_reset();
    succ = 1'b1; tick(); succ = 1'b0;
    n_cmp++; if (succ_cnt !== 16'd0) begin n_bad++; $display("FAIL idle_succ_ignored got %0d want 0", succ_cnt); end
    for (int i = 0; i < 3; i++) begin
      rs = 1'b1; tick(); rs = 1'b0;
      succ = 1'b1; tick(); succ = 1'b0;
    end
    n_cmp++; if (succ_cnt !== 16'd3) begin n_bad++; $display("FAIL idle_succ_cnt got %0d want 3", succ_cnt); end
    n_cmp++; if (round_cnt !== 16'd2) begin n_bad++; $display("FAIL idle_round_cnt got %0d want 2", round_cnt); end
    n_cmp++; if (verdict !== 2'b01) begin n_bad++; $display("FAIL idle_verdict got %0h want 1", verdict); end
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rec_valid got %0h want 0", rec_valid); end
  endtask

  task automatic test_lazy_verdict();
    do_reset();
    rs = 1'b1; tick(); rs = 1'b0;
    lazy = 1'b1; tick(); lazy = 1'b0;
    n_cmp++; if (lazy_cnt !== 16'd1) begin n_bad++; $display("FAIL lazy_cnt got %0d want 1", lazy_cnt); end
    n_cmp++; if (verdict !== 2'b11) begin n_bad++; $display("FAIL lazy_verdict got %0h want 3", verdict); end
    {succ, fail, lazy} = 3'b111; tick(); {succ, fail, lazy} = 3'b000;
    n_cmp++; if ({succ_cnt, fail_cnt, lazy_cnt} !== {16'd1, 16'd1, 16'd2}) begin n_bad++;
      $display("FAIL simul_counts got %0d/%0d/%0d want 1/1/2", succ_cnt, fail_cnt, lazy_cnt); end
    n_cmp++; if (verdict !== 2'b10) begin n_bad++; $display("FAIL simul_verdict got %0h want 2", verdict); end
  endtask

  task automatic test_fail_round0();
    do_reset();
    rs = 1'b1; tick(); rs = 1'b0;
    fail = 1'b1; tick();
    n_cmp++; if (rec_valid !== 1'b1) begin n_bad++; $display("FAIL r0_rec_valid_latency got %0h want 1", rec_valid); end
    tick(); tick(); fail = 1'b0;
    n_cmp++; if (fail_cnt !== 16'd3) begin n_bad++; $display("FAIL r0_fail_cnt got %0d want 3", fail_cnt); end
    n_cmp++; if (rec_round !== 16'd0) begin n_bad++; $display("FAIL r0_rec_round got %0d want 0", rec_round); end
    n_cmp++; if ({ffv, ffr} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL r0_first_fail got %0h want 10000", {ffv, ffr}); end
    n_cmp++; if (verdict !== 2'b10) begin n_bad++; $display("FAIL r0_verdict got %0h want 2", verdict); end
    tick();
    n_cmp++; if (rec_valid !== 1'b1) begin n_bad++; $display("FAIL r0_hold_valid got %0h want 1", rec_valid); end
    rdy = 1'b1; tick(); rdy = 1'b0;
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL r0_single_record got %0h want 0", rec_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    rs = 1'b1; tick(); rs = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      rs = 1'b1; tick(); rs = 1'b0;
      fail = 1'b1; tick(); fail = 1'b0;
      if (n == 4) begin
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %0h want 0", ovf); end
      end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0h want 1", ovf); end
    n_cmp++; if (fail_cnt !== 16'd5) begin n_bad++; $display("FAIL ovf_fail_cnt got %0d want 5", fail_cnt); end
    n_cmp++; if (ffr !== 16'd1) begin n_bad++; $display("FAIL ovf_first_round got %0d want 1", ffr); end
    for (int e = 1; e <= 4; e++) begin
      n_cmp++; if ({rec_valid, rec_round} !== {1'b1, 16'(e)}) begin n_bad++;
        $display("FAIL ovf_drain got v=%0h r=%0d want v=1 r=%0d", rec_valid, rec_round, e); end
      rdy = 1'b1; tick(); rdy = 1'b0;
    end
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got %0h want 0", rec_valid); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0h want 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    rs = 1'b1; tick(); rs = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      rs = 1'b1; tick(); rs = 1'b0;
      fail = 1'b1; tick(); fail = 1'b0;
    end
    rs = 1'b1; tick(); rs = 1'b0;
    fail = 1'b1; rdy = 1'b1; tick(); fail = 1'b0; rdy = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL pp_overflow got %0h want 0", ovf); end
    n_cmp++; if (rec_round !== 16'd2) begin n_bad++; $display("FAIL pp_head got %0d want 2", rec_round); end
    for (int e = 2; e <= 5; e++) begin
      n_cmp++; if ({rec_valid, rec_round} !== {1'b1, 16'(e)}) begin n_bad++;
        $display("FAIL pp_drain got v=%0h r=%0d want v=1 r=%0d", rec_valid, rec_round, e); end
      rdy = 1'b1; tick(); rdy = 1'b0;
    end
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty got %0h want 0", rec_valid); end
  endtask

  task automatic test_boundary_clr();
    do_reset();
    rs = 1'b1; tick(); tick();
    fail = 1'b1; tick(); rs = 1'b0;
    tick(); fail = 1'b0;
    rs = 1'b1; tick(); rs = 1'b0;
    fail = 1'b1; tick(); fail = 1'b0;
    n_cmp++; if (fail_cnt !== 16'd3) begin n_bad++; $display("FAIL bnd_fail_cnt got %0d want 3", fail_cnt); end
    n_cmp++; if (ffr !== 16'd2) begin n_bad++; $display("FAIL bnd_first_round got %0d want 2", ffr); end
    n_cmp++; if ({rec_valid, rec_round} !== {1'b1, 16'd2}) begin n_bad++;
      $display("FAIL bnd_rec0 got v=%0h r=%0d want v=1 r=2", rec_valid, rec_round); end
    rdy = 1'b1; tick();
    n_cmp++; if ({rec_valid, rec_round} !== {1'b1, 16'd3}) begin n_bad++;
      $display("FAIL bnd_rec1 got v=%0h r=%0d want v=1 r=3", rec_valid, rec_round); end
    clr = 1'b1; succ = 1'b1; tick(); clr = 1'b0; succ = 1'b0; rdy = 1'b0;
    n_cmp++; if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL clr_rec_valid got %0h want 0", rec_valid); end
    n_cmp++; if ({succ_cnt, fail_cnt, round_cnt, rec_round} !== 64'd0) begin n_bad++;
      $display("FAIL clr_counts got %0h want 0", {succ_cnt, fail_cnt, round_cnt, rec_round}); end
    n_cmp++; if ({ffv, ffr, ovf, verdict} !== 20'd0) begin n_bad++;
      $display("FAIL clr_flags got %0h want 0", {ffv, ffr, ovf, verdict}); end
    rs = 1'b1; fail = 1'b1; tick(); rs = 1'b0; fail = 1'b0;
    n_cmp++; if ({rec_valid, rec_round, round_cnt, fail_cnt} !== {1'b1, 16'd0, 16'd0, 16'd1}) begin
      n_bad++; $display("FAIL idle_run_fail got v=%0h r=%0d rc=%0d fc=%0d want 1/0/0/1",
                        rec_valid, rec_round, round_cnt, fail_cnt); end
  endtask

  task automatic test_saturate_wrap();
    do_reset();
    rs1 = 1'b1; tick(); rs1 = 1'b0;
    n_cmp++; if (round_cnt1 !== 4'd0) begin n_bad++; $display("FAIL w4_first_round got %0d want 0", round_cnt1); end
    succ1 = 1'b1; repeat (20) tick(); succ1 = 1'b0;
    n_cmp++; if (succ_cnt1 !== 4'd15) begin n_bad++; $display("FAIL w4_succ_sat got %0d want 15", succ_cnt1); end
    n_cmp++; if (verdict1 !== 2'b01) begin n_bad++; $display("FAIL w4_verdict got %0h want 1", verdict1); end
    rs1 = 1'b1; repeat (15) tick(); rs1 = 1'b0;
    n_cmp++; if (round_cnt1 !== 4'd15) begin n_bad++; $display("FAIL w4_round15 got %0d want 15", round_cnt1); end
    rs1 = 1'b1; tick(); rs1 = 1'b0;
    n_cmp++; if (round_cnt1 !== 4'd0) begin n_bad++; $display("FAIL w4_round_wrap got %0d want 0", round_cnt1); end
    n_cmp++; if (succ_cnt1 !== 4'd15) begin n_bad++; $display("FAIL w4_succ_hold got %0d want 15", succ_cnt1); end
  endtask

  initial begin
    rst_n = 1'b0;
    {clr, rs, succ, fail, lazy, rdy} = '0;
    {clr1, rs1, succ1, fail1, lazy1, rdy1} = '0;
    test_reset();
    test_idle_succ();
    test_lazy_verdict();
    test_fail_round0();
    test_overflow();
    test_full_push_pop();
    test_boundary_clr();
    test_saturate_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
